// File: rtl/d_branch_pkg.sv
// Shared encodings for the decode-stage branch/jump sequencer:
// branch and jump op codes, PC select values and FSM states.
package d_branch_pkg;

  localparam logic [2:0] BOP_NONE = 3'b000;
  localparam logic [2:0] BOP_BEQ  = 3'b001;
  localparam logic [2:0] BOP_BNE  = 3'b010;
  localparam logic [2:0] BOP_BLEZ = 3'b011;
  localparam logic [2:0] BOP_BGTZ = 3'b100;
  localparam logic [2:0] BOP_BLTZ = 3'b101;
  localparam logic [2:0] BOP_BGEZ = 3'b110;
  localparam logic [2:0] BOP_RSVD = 3'b111;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_J    = 2'b01;
  localparam logic [1:0] JMP_JR   = 2'b10;
  localparam logic [1:0] JMP_RSVD = 2'b11;

  localparam logic [1:0] PC_SEL_PC4    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
  localparam logic [1:0] PC_SEL_RS     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // Reserved code 111 falls out as "not a branch".
  function automatic logic is_branch_op(input logic [2:0] bop);
    return (bop != BOP_NONE) && (bop != BOP_RSVD);
  endfunction

endpackage

// File: rtl/d_branch_cmp.sv
// Combinational branch condition evaluator; the zero-compare forms treat rs
// as a signed 32-bit value.
module d_branch_cmp
  import d_branch_pkg::*;
(
  input  logic [2:0]  bop,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        taken
);

  logic signed [31:0] rs_s;

  assign rs_s = rs;

  always_comb begin
    taken = 1'b0;
    case (bop)
      BOP_BEQ:  taken = (rs == rt);
      BOP_BNE:  taken = (rs != rt);
      BOP_BLEZ: taken = (rs_s <= 32'sd0);
      BOP_BGTZ: taken = (rs_s >  32'sd0);
      BOP_BLTZ: taken = (rs_s <  32'sd0);
      BOP_BGEZ: taken = (rs_s >= 32'sd0);
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/d_branch_seq.sv
// Decode-stage control-flow sequencer: waits for operands, resolves the
// branch/jump, then drives a one-slot redirect with flush and jal link.
module d_branch_seq
  import d_branch_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [1:0]       i_jump,
  input  logic [2:0]       i_bop,
  input  logic             i_aluPC4,
  input  logic [31:0]      i_rs_val,
  input  logic [31:0]      i_rt_val,
  input  logic             i_rs_rdy,
  input  logic             i_rt_rdy,
  input  logic             i_ex_stall,
  output logic [1:0]       o_pc_sel,
  output logic             o_flush_fd,
  output logic             o_stall_fd,
  output logic             o_link,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_taken_cnt
);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             link_q, link_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic is_br, is_jmp, is_jr, is_cf;
  logic need_rs, need_rt, ops_ready;
  logic cond_taken, taken, can_resolve, resolve;

  assign is_br   = is_branch_op(i_bop);
  assign is_jmp  = (i_jump == JMP_J);
  assign is_jr   = (i_jump == JMP_JR);
  assign is_cf   = i_valid && (is_br || is_jmp || is_jr);
  assign need_rs = is_br || is_jr;
  assign need_rt = (i_bop == BOP_BEQ) || (i_bop == BOP_BNE);

  assign ops_ready   = (!need_rs || i_rs_rdy) && (!need_rt || i_rt_rdy);
  assign taken       = is_jmp || is_jr || cond_taken;
  assign can_resolve = is_cf && ops_ready && !i_ex_stall;
  assign resolve     = (state_q != ST_REDIRECT) && can_resolve;

  d_branch_cmp u_cmp (
    .bop   (i_bop),
    .rs    (i_rs_val),
    .rt    (i_rt_val),
    .taken (cond_taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= PC_SEL_PC4;
      link_q      <= 1'b0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      link_q      <= link_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  // IDLE and WAIT share the resolve path; a vanished op drops back to IDLE.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    link_d  = link_q;
    case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (!is_cf) begin
          state_d = ST_IDLE;
        end else if (can_resolve) begin
          state_d = taken ? ST_REDIRECT : ST_IDLE;
          if (taken) begin
            sel_d  = is_jmp ? PC_SEL_JUMP : (is_jr ? PC_SEL_RS : PC_SEL_BRANCH);
            link_d = is_jmp && i_aluPC4;
          end
        end else if (!ops_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_REDIRECT: begin
        if (!i_ex_stall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    br_cnt_d    = br_cnt_q + {{(CNT_W-1){1'b0}}, resolve};
    taken_cnt_d = taken_cnt_q + {{(CNT_W-1){1'b0}}, resolve && taken};
  end

  always_comb begin
    o_pc_sel   = PC_SEL_PC4;
    o_flush_fd = 1'b0;
    o_link     = 1'b0;
    o_busy     = 1'b0;
    o_stall_fd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_stall_fd = (is_cf && !ops_ready) || i_ex_stall;
      end
      ST_WAIT: begin
        o_busy     = 1'b1;
        o_stall_fd = (is_cf && !ops_ready) || i_ex_stall;
      end
      ST_REDIRECT: begin
        o_busy     = 1'b1;
        o_pc_sel   = sel_q;
        o_flush_fd = 1'b1;
        o_link     = link_q && !i_ex_stall;
      end
      default: ;
    endcase
  end

  assign o_br_cnt    = br_cnt_q;
  assign o_taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_d_branch_seq.sv
// Directed bench for d_branch_seq: a table of single-op vectors plus
// hand-written multi-cycle sequences; a 4-bit-counter copy covers wrap.
module tb_d_branch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [1:0]  i_jump;
  logic [2:0]  i_bop;
  logic        i_aluPC4;
  logic [31:0] i_rs_val, i_rt_val;
  logic        i_rs_rdy, i_rt_rdy, i_ex_stall;

  logic [1:0]  o_pc_sel;
  logic        o_flush_fd, o_stall_fd, o_link, o_busy;
  logic [15:0] o_br_cnt, o_taken_cnt;

  logic [1:0]  s_pc_sel;
  logic        s_flush_fd, s_stall_fd, s_link, s_busy;
  logic [3:0]  s_br_cnt, s_taken_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_br   = '0;
  logic [15:0] exp_tk   = '0;

  typedef struct packed {
    logic [1:0]  jump;
    logic [2:0]  bop;
    logic        pc4;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_cf;
    logic        exp_taken;
    logic [1:0]  exp_sel;
    logic        exp_link;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  d_branch_seq #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_jump(i_jump), .i_bop(i_bop),
    .i_aluPC4(i_aluPC4), .i_rs_val(i_rs_val), .i_rt_val(i_rt_val),
    .i_rs_rdy(i_rs_rdy), .i_rt_rdy(i_rt_rdy), .i_ex_stall(i_ex_stall),
    .o_pc_sel(o_pc_sel), .o_flush_fd(o_flush_fd), .o_stall_fd(o_stall_fd),
    .o_link(o_link), .o_busy(o_busy), .o_br_cnt(o_br_cnt), .o_taken_cnt(o_taken_cnt)
  );

  // Narrow-counter copy sees identical traffic so wrap shows up within a few ops.
  d_branch_seq #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_jump(i_jump), .i_bop(i_bop),
    .i_aluPC4(i_aluPC4), .i_rs_val(i_rs_val), .i_rt_val(i_rt_val),
    .i_rs_rdy(i_rs_rdy), .i_rt_rdy(i_rt_rdy), .i_ex_stall(i_ex_stall),
    .o_pc_sel(s_pc_sel), .o_flush_fd(s_flush_fd), .o_stall_fd(s_stall_fd),
    .o_link(s_link), .o_busy(s_busy), .o_br_cnt(s_br_cnt), .o_taken_cnt(s_taken_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] j, input logic [2:0] b,
                               input logic p, input logic [31:0] rs, input logic [31:0] rt,
                               input logic rsr, input logic rtr, input logic st);
    @(negedge clk);
    i_valid = v; i_jump = j; i_bop = b; i_aluPC4 = p;
    i_rs_val = rs; i_rt_val = rt; i_rs_rdy = rsr; i_rt_rdy = rtr; i_ex_stall = st;
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic checkCounters(input string name);
    checkOutput({name, " br_cnt"}, 32'(o_br_cnt), 32'(exp_br));
    checkOutput({name, " taken_cnt"}, 32'(o_taken_cnt), 32'(exp_tk));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //              jump   bop     pc4  rs            rt        cf    tkn   sel    link
    vecs[0]  = '{2'b00, 3'b001, 1'b0, 32'h5,        32'h5, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[1]  = '{2'b00, 3'b010, 1'b0, 32'h7,        32'h7, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[2]  = '{2'b00, 3'b100, 1'b0, 32'h80000000, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[3]  = '{2'b00, 3'b101, 1'b0, 32'h80000000, 32'h0, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[4]  = '{2'b00, 3'b011, 1'b0, 32'h0,        32'h0, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[5]  = '{2'b00, 3'b011, 1'b0, 32'h1,        32'h0, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[6]  = '{2'b00, 3'b110, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[7]  = '{2'b00, 3'b110, 1'b0, 32'h0,        32'h0, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[8]  = '{2'b00, 3'b100, 1'b0, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[9]  = '{2'b00, 3'b001, 1'b1, 32'h5,        32'h6, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[10] = '{2'b00, 3'b010, 1'b0, 32'h1,        32'h2, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[11] = '{2'b01, 3'b000, 1'b0, 32'h0,        32'h0, 1'b1, 1'b1, 2'b10, 1'b0};
    vecs[12] = '{2'b01, 3'b000, 1'b1, 32'h0,        32'h0, 1'b1, 1'b1, 2'b10, 1'b1};
    vecs[13] = '{2'b10, 3'b000, 1'b0, 32'h100,      32'h0, 1'b1, 1'b1, 2'b11, 1'b0};
    vecs[14] = '{2'b00, 3'b111, 1'b0, 32'h0,        32'h0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[15] = '{2'b11, 3'b000, 1'b1, 32'h0,        32'h0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[16] = '{2'b00, 3'b101, 1'b1, 32'h5,        32'h0, 1'b1, 1'b0, 2'b00, 1'b0};

    rst = 1'b1;
    i_valid = 0; i_jump = 0; i_bop = 0; i_aluPC4 = 0;
    i_rs_val = 0; i_rt_val = 0; i_rs_rdy = 1; i_rt_rdy = 1; i_ex_stall = 0;

    // Reset values; stall output still follows i_ex_stall while in reset.
    applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("reset stall_fd follows ex_stall", 32'(o_stall_fd), 32'h1);
    checkOutput("reset pc_sel", 32'(o_pc_sel), 32'h0);
    checkOutput("reset flush", 32'(o_flush_fd), 32'h0);
    checkOutput("reset link", 32'(o_link), 32'h0);
    checkOutput("reset busy", 32'(o_busy), 32'h0);
    checkCounters("reset");
    applyIdle();
    checkOutput("reset stall_fd low", 32'(o_stall_fd), 32'h0);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      applyStimulus(1'b1, vecs[k].jump, vecs[k].bop, vecs[k].pc4, vecs[k].rs, vecs[k].rt,
                    1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("vec%0d resolve stall_fd", k), 32'(o_stall_fd), 32'h0);
      checkOutput($sformatf("vec%0d resolve pc_sel", k), 32'(o_pc_sel), 32'h0);
      if (vecs[k].exp_cf) exp_br++;
      if (vecs[k].exp_taken) exp_tk++;
      applyIdle();
      checkOutput($sformatf("vec%0d pc_sel", k), 32'(o_pc_sel), 32'(vecs[k].exp_sel));
      checkOutput($sformatf("vec%0d flush", k), 32'(o_flush_fd), 32'(vecs[k].exp_taken));
      checkOutput($sformatf("vec%0d link", k), 32'(o_link), 32'(vecs[k].exp_link));
      checkOutput($sformatf("vec%0d busy", k), 32'(o_busy), 32'(vecs[k].exp_taken));
      checkCounters($sformatf("vec%0d", k));
      if (vecs[k].exp_taken) begin
        applyIdle();
        checkOutput($sformatf("vec%0d flush one cycle", k), 32'(o_flush_fd), 32'h0);
        checkOutput($sformatf("vec%0d pc_sel back", k), 32'(o_pc_sel), 32'h0);
        checkOutput($sformatf("vec%0d busy back", k), 32'(o_busy), 32'h0);
      end
    end

    // ex_stall alone in IDLE: hold in IDLE, resolve once the stall lifts.
    applyStimulus(1'b1, 2'b00, 3'b001, 1'b0, 32'h3, 32'h3, 1'b1, 1'b1, 1'b1);
    checkOutput("idle-stall stall_fd", 32'(o_stall_fd), 32'h1);
    checkOutput("idle-stall busy", 32'(o_busy), 32'h0);
    applyStimulus(1'b1, 2'b00, 3'b001, 1'b0, 32'h3, 32'h3, 1'b1, 1'b1, 1'b0);
    checkOutput("idle-stall stayed idle", 32'(o_busy), 32'h0);
    checkOutput("idle-stall released stall_fd", 32'(o_stall_fd), 32'h0);
    exp_br++; exp_tk++;
    applyIdle();
    checkOutput("idle-stall pc_sel", 32'(o_pc_sel), 32'h1);
    checkOutput("idle-stall flush", 32'(o_flush_fd), 32'h1);
    checkCounters("idle-stall");
    applyIdle();

    // jr waiting three cycles for rs, then redirect to rs.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 2'b10, 3'b000, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("jr-wait c%0d stall_fd", c), 32'(o_stall_fd), 32'h1);
      checkOutput($sformatf("jr-wait c%0d busy", c), 32'(o_busy), (c == 0) ? 32'h0 : 32'h1);
    end
    applyStimulus(1'b1, 2'b10, 3'b000, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("jr-wait ready stall_fd", 32'(o_stall_fd), 32'h0);
    checkOutput("jr-wait ready busy", 32'(o_busy), 32'h1);
    exp_br++; exp_tk++;
    applyIdle();
    checkOutput("jr-wait pc_sel", 32'(o_pc_sel), 32'h3);
    checkOutput("jr-wait flush", 32'(o_flush_fd), 32'h1);
    checkCounters("jr-wait");
    applyIdle();
    checkOutput("jr-wait flush done", 32'(o_flush_fd), 32'h0);

    // jal held in REDIRECT by a 2-cycle ex_stall; new ops in the slot are ignored.
    applyStimulus(1'b1, 2'b01, 3'b000, 1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    exp_br++; exp_tk++;
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 2'b01, 3'b000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
      checkOutput($sformatf("jal-hold c%0d pc_sel", c), 32'(o_pc_sel), 32'h2);
      checkOutput($sformatf("jal-hold c%0d flush", c), 32'(o_flush_fd), 32'h1);
      checkOutput($sformatf("jal-hold c%0d link", c), 32'(o_link), 32'h0);
      checkOutput($sformatf("jal-hold c%0d stall_fd", c), 32'(o_stall_fd), 32'h0);
    end
    applyStimulus(1'b1, 2'b01, 3'b000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("jal-hold exit pc_sel", 32'(o_pc_sel), 32'h2);
    checkOutput("jal-hold exit flush", 32'(o_flush_fd), 32'h1);
    checkOutput("jal-hold exit link", 32'(o_link), 32'h1);
    applyIdle();
    checkOutput("jal-hold after flush", 32'(o_flush_fd), 32'h0);
    checkOutput("jal-hold after link", 32'(o_link), 32'h0);
    checkCounters("jal-hold");

    // i_valid drops while in WAIT: back to IDLE, nothing counted.
    applyStimulus(1'b1, 2'b00, 3'b001, 1'b0, 32'h1, 32'h1, 1'b1, 1'b0, 1'b0);
    checkOutput("drop stall_fd", 32'(o_stall_fd), 32'h1);
    applyStimulus(1'b1, 2'b00, 3'b001, 1'b0, 32'h1, 32'h1, 1'b1, 1'b0, 1'b0);
    checkOutput("drop wait busy", 32'(o_busy), 32'h1);
    applyIdle();
    checkOutput("drop invalid busy", 32'(o_busy), 32'h1);
    checkOutput("drop invalid stall_fd", 32'(o_stall_fd), 32'h0);
    applyIdle();
    checkOutput("drop idle busy", 32'(o_busy), 32'h0);
    checkOutput("drop no flush", 32'(o_flush_fd), 32'h0);
    checkCounters("drop");

    // Reset in the middle of a REDIRECT kills the flush at once.
    applyStimulus(1'b1, 2'b01, 3'b000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    applyIdle();
    checkOutput("rst-redir pre flush", 32'(o_flush_fd), 32'h1);
    rst = 1'b1;
    #1;
    exp_br = '0; exp_tk = '0;
    checkOutput("rst-redir flush", 32'(o_flush_fd), 32'h0);
    checkOutput("rst-redir pc_sel", 32'(o_pc_sel), 32'h0);
    checkOutput("rst-redir busy", 32'(o_busy), 32'h0);
    checkCounters("rst-redir");
    @(negedge clk);
    rst = 1'b0;
    applyIdle();
    checkOutput("rst-redir post flush", 32'(o_flush_fd), 32'h0);

    // Reset during WAIT: no redirect after release.
    applyStimulus(1'b1, 2'b10, 3'b000, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b10, 3'b000, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst-wait pre busy", 32'(o_busy), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("rst-wait busy", 32'(o_busy), 32'h0);
    checkOutput("rst-wait stall_fd follows", 32'(o_stall_fd), 32'h1);
    applyIdle();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      applyIdle();
      checkOutput($sformatf("rst-wait c%0d flush", c), 32'(o_flush_fd), 32'h0);
      checkOutput($sformatf("rst-wait c%0d pc_sel", c), 32'(o_pc_sel), 32'h0);
      checkOutput($sformatf("rst-wait c%0d busy", c), 32'(o_busy), 32'h0);
    end
    checkCounters("rst-wait");

    // Counter wrap: 15 taken j ops bring the 4-bit copy to F, one more wraps it.
    for (int n = 0; n < 16; n++) begin
      applyStimulus(1'b1, 2'b01, 3'b000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      exp_br++; exp_tk++;
      applyIdle();
      if (n == 14) begin
        checkOutput("wrap small taken at F", 32'(s_taken_cnt), 32'hF);
        checkOutput("wrap small br at F", 32'(s_br_cnt), 32'hF);
      end
    end
    checkOutput("wrap small taken to 0", 32'(s_taken_cnt), 32'(exp_tk[3:0]));
    checkOutput("wrap small br to 0", 32'(s_br_cnt), 32'(exp_br[3:0]));
    checkCounters("wrap main");
    applyIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
